// File: rtl/load_store_unit_if.sv
// Request/response and DataMemory signals of the load/store unit.
// The slave modport is the unit's own view; master is the execute stage plus memory.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              WE;
  logic [3:0]        BE;
  logic [ADDR_W-1:0] A;
  logic [31:0]       WD;
  logic [31:0]       RD;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, RD,
    output req_ready, resp_valid, resp_rdata, WE, BE, A, WD
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, RD,
    input  req_ready, resp_valid, resp_rdata, WE, BE, A, WD
  );

endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into word-aligned memory beats,
// splitting accesses that straddle a word boundary. Big-endian lane order.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} state_e;

  state_e            state_q;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       rbuf_q;

  logic              ready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] wd_q;

  // Lane plan spans two words: span_be[7:4]/span_wd[63:32] are the first beat.
  logic [1:0]        p_size;
  logic [1:0]        p_off;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] left;
  logic [7:0]        span_be;
  logic [63:0]       span_wd;

  always_comb begin
    if (state_q == StIdle) begin
      p_size  = bus.req_size;
      p_off   = bus.req_addr[1:0];
      p_wdata = bus.req_wdata;
    end else begin
      p_size  = size_q;
      p_off   = off_q;
      p_wdata = wdata_q;
    end
    case (p_size)
      2'b00: begin
        span_be = 8'h80 >> p_off;
        left    = {p_wdata[7:0], 24'h0};
      end
      2'b01: begin
        span_be = 8'hc0 >> p_off;
        left    = {p_wdata[15:0], 16'h0};
      end
      default: begin
        span_be = 8'hf0 >> p_off;
        left    = p_wdata;
      end
    endcase
    span_wd = {left, 32'h0} >> {p_off, 3'b000};
  end

  // Load bytes in address order; the last lane of the second word is never needed.
  logic [31:0]       rd_lanes;
  logic [55:0]       buf_d;
  logic [31:0]       al;
  logic [DATA_W-1:0] ext;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_lanes[8*i +: 8] = bus.RD[8*i +: 8] & {8{be_q[i]}};
    end
    buf_d = (state_q == StAcc1) ? {rbuf_q, rd_lanes[31:8]} : {rd_lanes, 24'h0};
    case (off_q)
      2'd0:    al = buf_d[55:24];
      2'd1:    al = buf_d[47:16];
      2'd2:    al = buf_d[39:8];
      default: al = buf_d[31:0];
    endcase
    case (size_q)
      2'b00:   ext = {{24{signed_q & al[31]}}, al[31:24]};
      2'b01:   ext = {{16{signed_q & al[31]}}, al[31:16]};
      default: ext = al;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      be_q     <= 4'b0000;
      a_q      <= '0;
      wd_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      be_q     <= 4'b0000;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q  <= StAcc0;
            ready_q  <= 1'b0;
            we_q     <= bus.req_we;
            signed_q <= bus.req_signed;
            size_q   <= bus.req_size;
            off_q    <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata;
            mem_we_q <= bus.req_we;
            be_q     <= span_be[7:4];
            a_q      <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            wd_q     <= bus.req_we ? span_wd[63:32] : '0;
          end
        end
        StAcc0: begin
          rbuf_q <= rd_lanes;
          if (|span_be[3:0]) begin
            state_q  <= StAcc1;
            mem_we_q <= we_q;
            be_q     <= span_be[3:0];
            a_q      <= a_q + ADDR_W'(4);
            wd_q     <= we_q ? span_wd[31:0] : '0;
          end else begin
            state_q  <= StDone;
            rvalid_q <= 1'b1;
            rdata_q  <= we_q ? '0 : ext;
          end
        end
        StAcc1: begin
          state_q  <= StDone;
          rvalid_q <= 1'b1;
          rdata_q  <= we_q ? '0 : ext;
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.WE         = mem_we_q;
  assign bus.BE         = be_q;
  assign bus.A          = a_q;
  assign bus.WD         = wd_q;

endmodule
